// File: rtl/pwm_led_if.sv
// Control/status bundle for pwm_led_bank: user-side levels and modes in,
// LED drive and period marker out.
interface pwm_led_if #(
  parameter int CHANNELS = 4,
  parameter int PWM_BITS = 8
);
  logic                         enable;
  logic [2*CHANNELS-1:0]        mode;
  logic [PWM_BITS*CHANNELS-1:0] level;
  logic [CHANNELS-1:0]          led;
  logic                         period_tick;

  modport master (
    output enable, mode, level,
    input  led, period_tick
  );

  modport slave (
    input  enable, mode, level,
    output led, period_tick
  );
endinterface

// File: rtl/pwm_led_bank.sv
// Multi-channel PWM LED driver: shared timebase, per-channel off/static/breathe/blink.
// Define PWM_LED_GAMMA_EN for a squared perceptual duty curve (adds one output stage).
module pwm_led_bank #(
  parameter int CHANNELS      = 4,
  parameter int PWM_BITS      = 8,
  parameter int PWM_PRESCALE  = 2500,
  parameter int STEP_PRESCALE = 100000,
  parameter int PHASE_STAGGER = 0
) (
  input  logic    clk_50,
  input  logic    reset,
  pwm_led_if.slave bus
);
  localparam int W    = PWM_BITS;
  localparam int PCW  = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
  localparam int SCW  = (STEP_PRESCALE > 1) ? $clog2(STEP_PRESCALE) : 1;
  localparam int STAG = (1 << W) / CHANNELS;
  localparam logic [W-1:0]   MAX    = '1;
  localparam logic [PCW-1:0] PRE_TC = PCW'(PWM_PRESCALE - 1);
  localparam logic [SCW-1:0] STP_TC = SCW'(STEP_PRESCALE - 1);

  logic [PCW-1:0]      pre_cnt;
  logic [SCW-1:0]      step_cnt;
  logic [W-1:0]        pwm_pos;
  logic                pwm_tick;
  logic                step_tick;
  logic [W-1:0]        blevel [CHANNELS];
  logic [CHANNELS-1:0] dir_dn;
  logic [W-1:0]        duty   [CHANNELS];
  logic [CHANNELS-1:0] on_bit;
  logic [CHANNELS-1:0] led_q;
  logic                pt_q;

  function automatic logic [W-1:0] gam(input logic [W-1:0] d);
`ifdef PWM_LED_GAMMA_EN
    logic [2*W-1:0] sq;
    sq = {{W{1'b0}}, d} * {{W{1'b0}}, d};
    return (d == MAX) ? MAX : W'(sq >> W);
`else
    return d;
`endif
  endfunction

  assign pwm_tick  = bus.enable && (pre_cnt == PRE_TC);
  assign step_tick = bus.enable && (step_cnt == STP_TC);

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      pre_cnt  <= '0;
      step_cnt <= '0;
      pwm_pos  <= '0;
    end else if (bus.enable) begin
      pre_cnt  <= pwm_tick ? '0 : pre_cnt + PCW'(1);
      step_cnt <= step_tick ? '0 : step_cnt + SCW'(1);
      if (pwm_tick) pwm_pos <= pwm_pos + W'(1);
    end
  end

  // Triangle fade holds one extra step at each end, so level stays in 0..MAX.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      dir_dn <= '0;
      for (int i = 0; i < CHANNELS; i++)
        blevel[i] <= (PHASE_STAGGER != 0) ? W'(i * STAG) : '0;
    end else if (step_tick) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (!dir_dn[i]) begin
          if (blevel[i] == MAX) dir_dn[i] <= 1'b1;
          else                  blevel[i] <= blevel[i] + W'(1);
        end else begin
          if (blevel[i] == '0)  dir_dn[i] <= 1'b0;
          else                  blevel[i] <= blevel[i] - W'(1);
        end
      end
    end
  end

  always_comb begin
    on_bit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      duty[i] = '0;
      unique case (bus.mode[2*i +: 2])
        2'b00: duty[i] = '0;
        2'b01: duty[i] = gam(bus.level[W*i +: W]);
        2'b10: duty[i] = gam(blevel[i]);
        2'b11: duty[i] = dir_dn[i] ? '0 : MAX;
      endcase
      on_bit[i] = (pwm_pos < duty[i]) || (duty[i] == MAX);
    end
  end

`ifdef PWM_LED_GAMMA_EN
  logic [CHANNELS-1:0] led_s1;
  logic                tick_s1;
  logic                pt_s1;

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      led_s1  <= '0;
      tick_s1 <= 1'b0;
      pt_s1   <= 1'b0;
      led_q   <= '0;
      pt_q    <= 1'b0;
    end else if (!bus.enable) begin
      tick_s1 <= 1'b0;
      led_q   <= '0;
      pt_q    <= 1'b0;
    end else begin
      tick_s1 <= pwm_tick;
      if (pwm_tick) begin
        led_s1 <= on_bit;
        pt_s1  <= (pwm_pos == MAX);
      end
      if (tick_s1) led_q <= led_s1;
      pt_q <= tick_s1 && pt_s1;
    end
  end
`else
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      led_q <= '0;
      pt_q  <= 1'b0;
    end else if (!bus.enable) begin
      led_q <= '0;
      pt_q  <= 1'b0;
    end else begin
      if (pwm_tick) led_q <= on_bit;
      pt_q <= pwm_tick && (pwm_pos == MAX);
    end
  end
`endif

  assign bus.led         = led_q;
  assign bus.period_tick = pt_q;
endmodule

// File: tb/tb_pwm_led_bank.sv
// Bench for pwm_led_bank: closed-form timebase model feeding a per-cycle
// scoreboard, plus duty-window, hold and async-reset checks.
module tb_pwm_led_bank;
  localparam int CH = 2;
  localparam int PB = 4;
  localparam int PP = 2;
  localparam int SP = 4;

  logic clk_50 = 1'b0;
  logic reset  = 1'b1;

  pwm_led_if #(.CHANNELS(CH), .PWM_BITS(PB)) bus ();

  pwm_led_bank #(
    .CHANNELS(CH), .PWM_BITS(PB), .PWM_PRESCALE(PP),
    .STEP_PRESCALE(SP), .PHASE_STAGGER(0)
  ) dut (
    .clk_50(clk_50),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk_50 = ~clk_50;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int gm(input int d);
`ifdef PWM_LED_GAMMA_EN
    return (d == 15) ? 15 : (d * d) >> 4;
`else
    return d;
`endif
  endfunction

  // Breathe level/direction derived directly from elapsed step count.
  function automatic logic model_on(input int ch, input int pos, input int tt);
    int ph;
    int d;
    logic [1:0] md;
    ph = (tt / SP) % 32;
    md = bus.mode[2*ch +: 2];
    case (md)
      2'b00:   d = 0;
      2'b01:   d = gm(int'(bus.level[4*ch +: 4]));
      2'b10:   d = gm(ph < 16 ? ph : 31 - ph);
      default: d = (ph < 16) ? 15 : 0;
    endcase
    return (pos < d) || (d == 15);
  endfunction

  logic [2:0]    sb [$];
  int            t = 0;
  int            pos;
  logic          tick;
  logic [CH-1:0] nl;
  logic [CH-1:0] o_led = '0;
  logic          o_pt  = 1'b0;
  logic          p_v   = 1'b0;
  logic [CH-1:0] p_led = '0;
  logic          p_pt  = 1'b0;

  always @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      t = 0; o_led = '0; o_pt = 1'b0;
      p_v = 1'b0; p_led = '0; p_pt = 1'b0;
      sb.delete();
    end else begin
      if (!bus.enable) begin
        o_led = '0; o_pt = 1'b0; p_v = 1'b0;
      end else begin
        tick = (t % PP) == PP - 1;
        pos  = (t / PP) % 16;
        for (int c = 0; c < CH; c++) nl[c] = model_on(c, pos, t);
`ifdef PWM_LED_GAMMA_EN
        if (p_v) o_led = p_led;
        o_pt  = p_v && p_pt;
        p_v   = tick;
        p_led = nl;
        p_pt  = (pos == 15);
`else
        if (tick) o_led = nl;
        o_pt = tick && (pos == 15);
`endif
        t++;
      end
      sb.push_back({o_led, o_pt});
    end
  end

  always @(negedge clk_50) begin
    logic [2:0] e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_led", 32'(bus.led), 32'(e[2:1]));
      chk("sb_period_tick", 32'(bus.period_tick), 32'(e[0]));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_50);
  endtask

  task automatic count_hi(input int ch, output int n);
    n = 0;
    repeat (32) begin
      @(negedge clk_50);
      n += int'(bus.led[ch]);
    end
  endtask

  int cnt;
  logic [PB-1:0] hold_pos;

  initial begin
    bus.enable = 1'b0;
    bus.mode   = '0;
    bus.level  = '0;
    cyc(3);
    chk("rst_led", 32'(bus.led), 0);
    chk("rst_pt", 32'(bus.period_tick), 0);
    reset = 1'b0;

    bus.enable = 1'b1;
    bus.mode   = 4'b10_01;
    bus.level  = 8'h04;
    cyc(100);
    count_hi(0, cnt);
    chk("static4_cnt", cnt, 2 * gm(4));

    bus.level = 8'h00;
    cyc(40);
    count_hi(0, cnt);
    chk("static0_cnt", cnt, 0);

    bus.level = 8'h0f;
    cyc(40);
    count_hi(0, cnt);
    chk("static15_cnt", cnt, 32);

    cyc(7);
    hold_pos   = dut.pwm_pos;
    bus.enable = 1'b0;
    cyc(10);
    chk("hold_pos", 32'(dut.pwm_pos), 32'(hold_pos));
    chk("hold_led", 32'(bus.led), 0);
    bus.enable = 1'b1;
    cyc(60);

    bus.mode = 4'b00_01;
    cyc(80);
    bus.mode = 4'b10_01;
    cyc(150);

    bus.mode = 4'b10_11;
    cyc(300);

    bus.mode  = 4'b10_01;
    bus.level = 8'h0f;
    cyc(40);
    chk("pre_rst_led0", 32'(bus.led[0]), 1);
    @(posedge clk_50);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_led", 32'(bus.led), 0);
    chk("async_rst_pt", 32'(bus.period_tick), 0);
    cyc(2);
    reset = 1'b0;
    chk("rst_pos", 32'(dut.pwm_pos), 0);
    cyc(60);

    bus.level = 8'h08;
    cyc(40);
    count_hi(0, cnt);
    chk("static8_cnt", cnt, 2 * gm(8));
    cyc(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
